load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: number of 32-bit words in the attached data memory (power of two).
REQ-002 SHALL have port I_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port I_rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port I_req  input  1  CPU access request, sampled only while idle.
REQ-005 SHALL have port I_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port I_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port I_addr  input  32  byte address.
REQ-008 SHALL have port I_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port O_busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port O_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port O_err  output  1  one-cycle pulse with O_done when the access was rejected.
REQ-012 SHALL have port O_rdata  output  32  load result, aligned and extended.
REQ-013 SHALL have port O_mem_memrw  output  1  data-memory write enable.
REQ-014 SHALL have port O_mem_address  output  32  data-memory word index.
REQ-015 SHALL have port O_mem_data  output  32  data-memory write data.
REQ-016 SHALL have port I_mem_data  input  32  data-memory read data, valid one cycle after the address is presented with write enable low.

Function
REQ-017 SHALL implement states IDLE, READ, MODIFY, WRITE, and SHALL accept a request only at an edge where the state is IDLE and I_req=1, latching I_we, I_funct3, I_addr and I_wdata.
REQ-018 SHALL reject the access (no memory write; O_done=O_err=1 in the next cycle; O_rdata unchanged; stay IDLE) when any of the following holds: funct3 is 011, 110 or 111; a store uses 100 or 101; H/HU with addr[0]=1; W with addr[1:0]!=0; addr >= 4*MEM_WORDS.
REQ-019 SHALL drive O_mem_address = latched addr[31:2] in READ, MODIFY and WRITE, and drive O_mem_address, O_mem_data and O_mem_memrw to 0 in IDLE.
REQ-020 Load SHALL follow IDLE->READ->MODIFY->IDLE with memrw=0. In MODIFY, the selected lane of I_mem_data SHALL be registered into O_rdata: sign-extended for B/H, zero-extended for BU/HU, the full word for W. O_done SHALL pulse in the following cycle (3 cycles after acceptance).
REQ-021 Store word SHALL follow IDLE->WRITE->IDLE, with memrw=1 and O_mem_data=wdata in WRITE; O_done SHALL pulse in the following cycle (2 cycles after acceptance).
REQ-022 Store byte/half SHALL follow IDLE->READ->MODIFY->IDLE. In MODIFY it SHALL assert memrw=1 with O_mem_data = I_mem_data, with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. O_done SHALL pulse in the following cycle.
REQ-023 Lane select SHALL be addr[1:0] for bytes (lane 0 = bits 7:0) and addr[1] for halves.
REQ-024 O_done SHALL never be high for two consecutive cycles per access; a new request SHALL be acceptable in the cycle O_done is high (back-to-back).
REQ-025 I_req while busy SHALL be ignored, not queued; input changes after acceptance SHALL have no effect on the access.
REQ-026 O_rdata SHALL change only on a successful load completion.

Reset
REQ-027 With I_rst_n low at a rising edge, the block SHALL go to IDLE with O_done=0, O_err=0, O_rdata=0 and all latched request fields cleared.
REQ-028 O_mem_memrw SHALL be forced to 0 combinationally while I_rst_n is low, so reset asserted during MODIFY or WRITE causes no memory write.
REQ-029 A request pending during reset SHALL be discarded; O_done SHALL not pulse for it.

Structure
REQ-030 The funct3 encodings and the state encodings SHALL live in the shared CPU defines header.
REQ-031 Lane extraction/extension and store merge SHALL be one combinational sub-module, lsu_lane_align, instantiated once.

Verification
REQ-032 Word M[5]=0x11223344; LB addr 0x15 -> O_rdata=0x00000033; LBU addr 0x17 -> 0x00000011, O_done 3 cycles after accept.
REQ-033 M[2]=0x80FF7F00; LH addr 0x0A -> 0xFFFF80FF; LHU -> 0x000080FF; LB addr 0x09 -> 0x0000007F.
REQ-034 M[3]=0xAABBCCDD; SB addr 0x0E wdata 0x12345678 -> M[3]=0xAA78CCDD; SH addr 0x0C wdata 0x0000BEEF -> 0xAA78BEEF; memrw high exactly one cycle each.
REQ-035 LW addr 0x06, SH addr 0x03, addr 0x400 (MEM_WORDS=256), funct3 011 -> O_done=O_err=1 one cycle after accept; memory unchanged.
REQ-036 SB in progress, I_rst_n low during MODIFY -> no memory write, state IDLE, O_done never pulses; next LW returns the original word.
REQ-037 Back-to-back: SW addr 0x20 data 0xCAFEF00D, I_req held high -> LW addr 0x20 accepted in the SW O_done cycle and returns 0xCAFEF00D; an extra I_req during busy is ignored.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared CPU defines for the load/store unit: RISC-V width codes, FSM states,
// and the width/alignment legality rule.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_MODIFY = 2'd2,
    ST_WRITE  = 2'd3
  } lsu_state_e;

  // True when the width code is illegal for this direction or the address is misaligned.
  function automatic logic lsu_bad_format(input logic       i_we,
                                          input logic [2:0] i_funct3,
                                          input logic [1:0] i_addr_lo);
    logic bad;
    case (i_funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = i_we;
      F3_H:    bad = i_addr_lo[0];
      F3_HU:   bad = i_we | i_addr_lo[0];
      F3_W:    bad = |i_addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: extracts and extends load lanes, and merges
// store bytes/halves into the word read back from memory.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  I_funct3,
  input  logic [1:0]  I_addr_lo,
  input  logic [31:0] I_mem_word,
  input  logic [31:0] I_wdata,
  output logic [31:0] O_load_data,
  output logic [31:0] O_store_word
);

  logic [4:0]  w_byte_shift;
  logic [4:0]  w_half_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte_shift = {I_addr_lo, 3'b000};
    w_half_shift = {I_addr_lo[1], 4'b0000};
    w_byte       = I_mem_word[w_byte_shift +: 8];
    w_half       = I_mem_word[w_half_shift +: 16];
    // NOTE: every output gets a default before the case so no path leaves a latch.
    O_load_data  = I_mem_word;
    O_store_word = I_wdata;
    case (I_funct3)
      F3_B: begin
        O_load_data                     = {{24{w_byte[7]}}, w_byte};
        O_store_word                    = I_mem_word;
        O_store_word[w_byte_shift +: 8] = I_wdata[7:0];
      end
      F3_BU: O_load_data = {24'h0, w_byte};
      F3_H: begin
        O_load_data                      = {{16{w_half[15]}}, w_half};
        O_store_word                     = I_mem_word;
        O_store_word[w_half_shift +: 16] = I_wdata[15:0];
      end
      F3_HU:   O_load_data = {16'h0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-request FSM bridging CPU byte/half/word accesses
// onto a word-wide synchronous data memory, with read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_err,
  output logic [31:0] O_rdata,
  output logic        O_mem_memrw,
  output logic [31:0] O_mem_address,
  output logic [31:0] O_mem_data,
  input  logic [31:0] I_mem_data
);

  localparam logic [32:0] LP_BYTE_LIMIT = 33'(MEM_WORDS) << 2;

  lsu_state_e  r_state, w_next;
  logic        r_we, r_done, r_err;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_accept, w_bad, w_busy, w_memrw;
  logic [31:0] w_load_data, w_store_word;

  assign w_accept = (r_state == ST_IDLE) && I_req;
  assign w_bad    = lsu_bad_format(I_we, I_funct3, I_addr[1:0]) ||
                    ({1'b0, I_addr} >= LP_BYTE_LIMIT);

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = (r_state != ST_IDLE);
    w_memrw = (r_state == ST_WRITE) || ((r_state == ST_MODIFY) && r_we);
    case (r_state)
      ST_IDLE:
        if (w_accept && !w_bad) w_next = (I_we && I_funct3 == F3_W) ? ST_WRITE : ST_READ;
      ST_READ:   w_next = ST_MODIFY;
      ST_MODIFY: w_next = ST_IDLE;
      ST_WRITE:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= (r_state == ST_MODIFY) || (r_state == ST_WRITE) || (w_accept && w_bad);
      r_err  <= w_accept && w_bad;
      if (w_accept) begin
        r_we     <= I_we;
        r_funct3 <= I_funct3;
        r_addr   <= I_addr;
        r_wdata  <= I_wdata;
      end
      if ((r_state == ST_MODIFY) && !r_we) r_rdata <= w_load_data;
    end
  end

  lsu_lane_align u_lane_align (
    .I_funct3    (r_funct3),
    .I_addr_lo   (r_addr[1:0]),
    .I_mem_word  (I_mem_data),
    .I_wdata     (r_wdata),
    .O_load_data (w_load_data),
    .O_store_word(w_store_word)
  );

  assign O_busy        = w_busy;
  assign O_done        = r_done;
  assign O_err         = r_err;
  assign O_rdata       = r_rdata;
  // NOTE: reset gates the write enable combinationally so a reset landing mid-store writes nothing.
  assign O_mem_memrw   = w_memrw & I_rst_n;
  assign O_mem_address = w_busy ? {2'b00, r_addr[31:2]} : '0;
  assign O_mem_data    = w_memrw ? w_store_word : '0;

endmodule
